// File: rtl/rx_measure_pkg.sv
// Shared constants for the receive measurement stage: XGMII control codes,
// measurement frame layout and the two-state frame FSM encoding.
package rx_measure_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  localparam logic [39:0] MAGIC_CODE_DEF    = 40'h01_23_45_67_89;
  localparam int unsigned TICKS_PER_SEC_DEF = 156250000;

  // Data word numbering: word 1 is the first word after the start/preamble word.
  localparam logic [3:0] WORD_SRC_IP = 4'd4;
  localparam logic [3:0] WORD_MAGIC  = 4'd6;
  localparam logic [3:0] WORD_TS_LO  = 4'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/rx_measure_if.sv
// XGMII receive bus (64-bit data, 8 lane control flags); no flow control.
interface rx_measure_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/rx_measure_term_detect.sv
// Combinational XGMII word classifier: lowest terminate lane, any error lane,
// and lane-0 aligned start.
module xgmii_term_detect
  import rx_measure_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic        term_valid,
  output logic [2:0]  term_lane,
  output logic        err_valid,
  output logic        start_valid
);

  always_comb begin
    term_valid = 1'b0;
    term_lane  = 3'd0;
    err_valid  = 1'b0;
    // Scan high to low so the lowest terminate lane wins.
    for (int k = 7; k >= 0; k--) begin
      if (rxc[k] && rxd[8*k +: 8] == XGMII_TERM) begin
        term_valid = 1'b1;
        term_lane  = 3'(k);
      end
      if (rxc[k] && rxd[8*k +: 8] == XGMII_ERROR) begin
        err_valid = 1'b1;
      end
    end
  end

  assign start_valid = (rxc == 8'h01) && (rxd[7:0] == XGMII_START);

endmodule

// File: rtl/rx_measure.sv
// Per-port receive measurement: frame/byte rates per window, one-way latency
// and source IP of measurement frames. Outputs registered; accepts a word every cycle.
module rx_measure
  import rx_measure_pkg::*;
#(
  parameter logic [39:0] MAGIC_CODE    = MAGIC_CODE_DEF,
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  rx_measure_if.slave  rx,
  input  logic [31:0]  global_counter,
  output logic [31:0]  rx_pps,
  output logic [31:0]  rx_throughput,
  output logic [23:0]  rx_latency,
  output logic [31:0]  rx_ipv4_ip,
  output logic [15:0]  rx_err_count
);

  localparam logic [31:0] WIN_RELOAD = 32'(TICKS_PER_SEC - 1);

  logic       term_valid, err_valid, start_valid;
  logic [2:0] term_lane;

  xgmii_term_detect u_term_detect (
    .rxd         (rx.xgmii_rxd),
    .rxc         (rx.xgmii_rxc),
    .term_valid  (term_valid),
    .term_lane   (term_lane),
    .err_valid   (err_valid),
    .start_valid (start_valid)
  );

  state_t      state;
  logic [3:0]  w;
  logic [15:0] bytes;
  logic [31:0] src_ip;
  logic        magic_hit;
  logic        meas_ok;
  logic [23:0] pend_lat;
  logic [31:0] win_cnt;
  logic [31:0] win_frames;
  logic [31:0] win_bytes;

  logic        in_frame, abort, commit, tick;
  logic [3:0]  cur_word;
  logic [15:0] frame_bytes;
  logic [31:0] frames_nxt, bytes_nxt;
  logic [23:0] ts_lo;
  logic [39:0] magic_field;
  logic [31:0] ip_field;
  logic        unused_gc_hi;

  assign in_frame    = (state == ST_FRAME);
  assign abort       = in_frame && (err_valid || start_valid);
  assign commit      = in_frame && !abort && term_valid;
  assign tick        = (win_cnt == 32'd0);
  assign cur_word    = (w == 4'd15) ? 4'd15 : w + 4'd1;
  assign frame_bytes = bytes + {13'd0, term_lane};
  assign frames_nxt  = win_frames + {31'd0, commit};
  assign bytes_nxt   = win_bytes + (commit ? {16'd0, frame_bytes} : 32'd0);

  assign ip_field    = {rx.xgmii_rxd[23:16], rx.xgmii_rxd[31:24],
                        rx.xgmii_rxd[39:32], rx.xgmii_rxd[47:40]};
  assign magic_field = {rx.xgmii_rxd[23:16], rx.xgmii_rxd[31:24], rx.xgmii_rxd[39:32],
                        rx.xgmii_rxd[47:40], rx.xgmii_rxd[55:48]};
  assign ts_lo       = {rx.xgmii_rxd[7:0], rx.xgmii_rxd[15:8], rx.xgmii_rxd[23:16]};
  // Latency is a 24-bit quantity, so only the low counter/timestamp bits matter.
  assign unused_gc_hi = ^global_counter[31:24];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      w             <= 4'd0;
      bytes         <= 16'd0;
      src_ip        <= 32'd0;
      magic_hit     <= 1'b0;
      meas_ok       <= 1'b0;
      pend_lat      <= 24'd0;
      win_cnt       <= WIN_RELOAD;
      win_frames    <= 32'd0;
      win_bytes     <= 32'd0;
      rx_pps        <= 32'd0;
      rx_throughput <= 32'd0;
      rx_latency    <= 24'd0;
      rx_ipv4_ip    <= 32'd0;
      rx_err_count  <= 16'd0;
    end else begin
      // Window accounting includes a commit landing on the tick cycle itself.
      if (tick) begin
        win_cnt       <= WIN_RELOAD;
        rx_pps        <= frames_nxt;
        rx_throughput <= bytes_nxt;
        win_frames    <= 32'd0;
        win_bytes     <= 32'd0;
      end else begin
        win_cnt    <= win_cnt - 32'd1;
        win_frames <= frames_nxt;
        win_bytes  <= bytes_nxt;
      end

      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            state     <= ST_FRAME;
            w         <= 4'd0;
            bytes     <= 16'd0;
            src_ip    <= 32'd0;
            magic_hit <= 1'b0;
            meas_ok   <= 1'b0;
            pend_lat  <= 24'd0;
          end
        end
        ST_FRAME: begin
          w <= cur_word;
          if (abort) begin
            if (rx_err_count != 16'hFFFF) begin
              rx_err_count <= rx_err_count + 16'd1;
            end
            // A start inside a frame aborts it and opens the next one at once.
            if (start_valid) begin
              state     <= ST_FRAME;
              w         <= 4'd0;
              bytes     <= 16'd0;
              src_ip    <= 32'd0;
              magic_hit <= 1'b0;
              meas_ok   <= 1'b0;
              pend_lat  <= 24'd0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (term_valid) begin
            state <= ST_IDLE;
            if (meas_ok) begin
              rx_latency <= pend_lat;
              rx_ipv4_ip <= src_ip;
            end
          end else begin
            bytes <= bytes + 16'd8;
            if (cur_word == WORD_SRC_IP) begin
              src_ip <= ip_field;
            end
            if (cur_word == WORD_MAGIC) begin
              magic_hit <= (magic_field == MAGIC_CODE);
            end
            if (cur_word == WORD_TS_LO) begin
              pend_lat <= global_counter[23:0] - ts_lo;
              meas_ok  <= magic_hit;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
